// File: rtl/raster_pixel_tx.sv
// raster_pixel_tx: buffers upstream grayscale pixels in a small FIFO and
// replays them as a gap-free H_LIMIT x V_LIMIT raster with a single-cycle
// start-of-frame strobe, a frame-done pulse and a sticky underflow flag.
module raster_pixel_tx #(
    parameter int unsigned H_LIMIT     = 800,
    parameter int unsigned H_START     = 0,
    parameter int unsigned V_LIMIT     = 525,
    parameter int unsigned DATA_SIZE   = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PRIME_LEVEL = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_is_new_read,
    output logic [DATA_SIZE-1:0] o_data,
    output logic [10:0]          o_hcnt,
    output logic [9:0]           o_vcnt,
    output logic                 o_frame_done,
    output logic                 o_underflow
);

    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;
    localparam int unsigned ACTIVE_TOTAL = (H_LIMIT - H_START) * V_LIMIT;
    localparam int unsigned ACC_W        = $clog2(ACTIVE_TOTAL + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] PRIME_C = CNT_W'(PRIME_LEVEL);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACTIVE_TOTAL);
    localparam logic [10:0]      H_FIRST = 11'(H_START);
    localparam logic [10:0]      H_LAST  = 11'(H_LIMIT - 1);
    localparam logic [9:0]       V_LAST  = 10'(V_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [10:0]          h_q, h_d;
    logic [9:0]           v_q, v_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [10:0]          hcnt_q, hcnt_d;
    logic [9:0]           vcnt_q, vcnt_d;
    logic                 new_q, new_d;
    logic                 done_pend_q, done_pend_d;
    logic                 done_q, done_d;
    logic                 uf_q, uf_d;

    logic ready, push, emit, last_px, col_active, pop_req, pop;

    // Blank leading columns only exist when H_START is non-zero; the split
    // keeps a degenerate unsigned compare against zero out of the netlist.
    if (H_START == 0) begin : g_no_blank
        // Every column carries FIFO data
        always_comb col_active = 1'b1;
    end else begin : g_blank
        // Columns before H_START are blank and do not consume FIFO data
        always_comb col_active = (h_q >= H_FIRST);
    end

    // Handshake and per-edge events derived from the registered state
    always_comb begin
        ready   = (state_q != IDLE) && (count_q < DEPTH_C) && (acc_q < ACC_MAX);
        push    = i_valid && ready;
        emit    = (state_q == STREAM) || ((state_q == PRIME) && (count_q >= PRIME_C));
        last_px = emit && (h_q == H_LAST) && (v_q == V_LAST);
        pop_req = emit && col_active;
        pop     = pop_req && (count_q != '0);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame end overrides whatever the current state chose
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = PRIME;
            PRIME:   if (emit) state_d = STREAM;
            STREAM:  state_d = STREAM;
            default: state_d = IDLE;
        endcase
        if (last_px) state_d = IDLE;
    end

    // FIFO, raster counters and registered outputs; an empty-FIFO pop still
    // advances h/v so the raster cadence never slips
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        uf_d        = uf_q;
        h_d         = h_q;
        v_d         = v_q;
        data_d      = '0;
        hcnt_d      = '0;
        vcnt_d      = '0;
        new_d       = 1'b0;
        done_pend_d = last_px;
        done_d      = done_pend_q;

        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if ((state_q == IDLE) && i_start) begin
            acc_d = '0;
            uf_d  = 1'b0;
        end else begin
            if (push) acc_d = acc_q + ACC_W'(1);
            if (pop_req && (count_q == '0)) uf_d = 1'b1;
        end

        if (emit) begin
            hcnt_d = h_q;
            vcnt_d = v_q;
            new_d  = (h_q == '0) && (v_q == '0);
            if (pop) data_d = mem_q[rd_ptr_q];
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end

        if (last_px) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            uf_q        <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            data_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            new_q       <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            uf_q        <= uf_d;
            h_q         <= h_d;
            v_q         <= v_d;
            data_q      <= data_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            new_q       <= new_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage; contents are don't-care whenever count is zero
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Output mapping
    always_comb begin
        o_ready       = ready;
        o_is_new_read = new_q;
        o_data        = data_q;
        o_hcnt        = hcnt_q;
        o_vcnt        = vcnt_q;
        o_frame_done  = done_q;
        o_underflow   = uf_q;
    end

endmodule

// File: tb/tb_raster_pixel_tx.sv
// Testbench for raster_pixel_tx: reference model with a pixel scoreboard
// queue, plus a second instance primed to full depth for backpressure.
module tb_raster_pixel_tx;

    localparam int HL = 8;
    localparam int HS = 2;
    localparam int VL = 2;
    localparam int FD = 8;
    localparam int PL = 4;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_valid;
    logic [3:0]  i_data;
    logic        o_ready, o_is_new_read, o_frame_done, o_underflow;
    logic [3:0]  o_data;
    logic [10:0] o_hcnt;
    logic [9:0]  o_vcnt;

    logic        bp_start, bp_valid;
    logic [3:0]  bp_data;
    logic        bp_ready, bp_new, bp_done, bp_uf;
    logic [3:0]  bp_dout;
    logic [10:0] bp_h;
    logic [9:0]  bp_v;

    always #5 clk = ~clk;

    raster_pixel_tx #(.H_LIMIT(HL), .H_START(HS), .V_LIMIT(VL), .DATA_SIZE(4),
                      .FIFO_DEPTH(FD), .PRIME_LEVEL(PL)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
        .i_data(i_data), .o_ready(o_ready), .o_is_new_read(o_is_new_read),
        .o_data(o_data), .o_hcnt(o_hcnt), .o_vcnt(o_vcnt),
        .o_frame_done(o_frame_done), .o_underflow(o_underflow));

    raster_pixel_tx #(.H_LIMIT(HL), .H_START(HS), .V_LIMIT(VL), .DATA_SIZE(4),
                      .FIFO_DEPTH(FD), .PRIME_LEVEL(FD)) dut_bp (
        .i_clk(clk), .i_rst(i_rst), .i_start(bp_start), .i_valid(bp_valid),
        .i_data(bp_data), .o_ready(bp_ready), .o_is_new_read(bp_new),
        .o_data(bp_dout), .o_hcnt(bp_h), .o_vcnt(bp_v),
        .o_frame_done(bp_done), .o_underflow(bp_uf));

    int n_total = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model of the main instance
    logic [3:0] sb_q[$];
    int         m_st = 0;
    int         m_acc = 0;
    int         m_h = 0;
    int         m_v = 0;
    logic       m_uf = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_live = 1'b0;
    logic       e_new, e_done, e_chk;
    logic [3:0] e_data;
    int         e_h, e_v;

    int         strobe_cyc = -1;
    int         done_cyc = -1;
    logic [3:0] cap [16];
    int         cap_idx = 16;
    int         acc_dut = 0;

    // backpressure instance bookkeeping
    logic [3:0] bp_q[$];
    logic       bp_en = 1'b0;
    logic       bp_st = 1'b0;
    logic [3:0] bp_next = 4'd1;
    int         bp_pushes = 0;
    int         bp_pos = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic v, input logic [3:0] d);
        logic       rdy_m, push, emit, last, bp_push;
        logic [3:0] pix, bexp;
        int         col;
        i_rst    = rst;
        i_start  = st;
        i_valid  = v;
        i_data   = d;
        bp_start = bp_st;
        bp_valid = bp_en;
        bp_data  = bp_next;
        #1;
        rdy_m = (m_st != 0) && (sb_q.size() < FD) && (m_acc < (HL - HS) * VL);
        if (m_live) check("o_ready", 32'(o_ready), 32'(rdy_m));
        if (v && o_ready === 1'b1) acc_dut++;
        bp_push = bp_en && (bp_ready === 1'b1) && !rst;
        if (bp_push) begin
            bp_q.push_back(bp_next);
            bp_pushes++;
        end
        if (rst) begin
            sb_q.delete();
            m_st = 0; m_acc = 0; m_h = 0; m_v = 0; m_uf = 1'b0; m_pend = 1'b0;
            e_new = 1'b0; e_done = 1'b0; e_data = '0; e_h = 0; e_v = 0; e_chk = 1'b1;
        end else begin
            push   = v && rdy_m;
            emit   = (m_st == 2) || (m_st == 1 && sb_q.size() >= PL);
            last   = emit && (m_h == HL - 1) && (m_v == VL - 1);
            e_done = m_pend;
            m_pend = last;
            e_chk  = emit;
            e_new  = emit && (m_h == 0) && (m_v == 0);
            e_h    = emit ? m_h : 0;
            e_v    = emit ? m_v : 0;
            pix    = '0;
            if (emit && m_h >= HS) begin
                if (sb_q.size() == 0) m_uf = 1'b1;
                else pix = sb_q.pop_front();
            end
            e_data = pix;
            if (push) begin
                sb_q.push_back(d);
                m_acc++;
            end
            if (m_st == 0 && st) begin
                m_st = 1; m_acc = 0; m_uf = 1'b0;
            end else if (m_st == 1 && emit) begin
                m_st = 2;
            end
            if (emit) begin
                if (m_h == HL - 1) begin
                    m_h = 0;
                    m_v = (m_v == VL - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end
            if (last) begin
                m_st = 0;
                sb_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bp_push) bp_next = bp_next + 4'd1;
        if (rst) m_live = 1'b1;
        check("o_is_new_read", 32'(o_is_new_read), 32'(e_new));
        check("o_frame_done", 32'(o_frame_done), 32'(e_done));
        check("o_underflow", 32'(o_underflow), 32'(m_uf));
        if (e_chk) begin
            check("o_data", 32'(o_data), 32'(e_data));
            check("o_hcnt", 32'(o_hcnt), 32'(e_h));
            check("o_vcnt", 32'(o_vcnt), 32'(e_v));
        end
        if (rst) check("o_ready_after_rst", 32'(o_ready), 32'd0);
        if (o_is_new_read === 1'b1) begin
            strobe_cyc = cyc;
            cap_idx = 0;
        end
        if (cap_idx < 16) begin
            cap[cap_idx] = o_data;
            cap_idx++;
        end
        if (o_frame_done === 1'b1) done_cyc = cyc;
        if (bp_pos < 0 && bp_new === 1'b1) bp_pos = 0;
        if (bp_pos >= 0 && bp_pos < 2 * HL) begin
            col  = bp_pos % HL;
            bexp = '0;
            if (col >= HS && bp_q.size() > 0) bexp = bp_q.pop_front();
            check("bp_data", 32'(bp_dout), 32'(bexp));
            check("bp_hcnt", 32'(bp_h), 32'(col));
            bp_pos++;
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0);
            if (done_cyc >= 0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_nominal(input string tag);
        logic [3:0] exp_seq [16];
        int c0;
        exp_seq = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                    4'd0, 4'd0, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
        cap_idx = 16; strobe_cyc = -1; done_cyc = -1;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        c0 = cyc;
        for (int k = 1; k <= 12; k++) step(1'b0, 1'b0, 1'b1, 4'(k));
        wait_done(tag);
        check({tag, "_strobe_cyc"}, 32'(strobe_cyc), 32'(c0 + 5));
        check({tag, "_done_gap"}, 32'(done_cyc - strobe_cyc), 32'd16);
        for (int i = 0; i < 16; i++) check({tag, "_seq"}, 32'(cap[i]), 32'(exp_seq[i]));
        check({tag, "_underflow"}, 32'(o_underflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   p;
        logic found;
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
        bp_start = 1'b0; bp_valid = 1'b0; bp_data = '0;

        // reset
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        check("idle_ignores_valid", 32'(o_ready), 32'd0);

        // nominal frame
        run_nominal("nominal");

        // priming hold-off
        strobe_cyc = -1; done_cyc = -1;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b1, 4'(k));
        for (int t = 0; t < 8; t++) step(1'b0, 1'b0, 1'b0, 4'd0);
        check("holdoff_no_strobe", 32'(strobe_cyc), 32'(-1));
        check("holdoff_ready", 32'(o_ready), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'd4);
        p = cyc;
        for (int k = 5; k <= 12; k++) step(1'b0, 1'b0, 1'b1, 4'(k));
        check("holdoff_strobe_cyc", 32'(strobe_cyc), 32'(p + 1));
        wait_done("holdoff");

        // underflow
        strobe_cyc = -1; done_cyc = -1;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, 4'(k));
        wait_done("uf");
        check("uf_done_gap", 32'(done_cyc - strobe_cyc), 32'd16);
        check("uf_sticky", 32'(o_underflow), 32'd1);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b0, 4'd0);
        check("uf_sticky_idle", 32'(o_underflow), 32'd1);

        // over-supply and cap; this start also clears the underflow flag
        done_cyc = -1; acc_dut = 0;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check("uf_clear", 32'(o_underflow), 32'd0);
        for (int k = 1; k <= 20; k++) step(1'b0, (k == 10), 1'b1, 4'(k));
        check("cap_accepted", 32'(acc_dut), 32'd12);
        wait_done("cap");

        // backpressure on the full-depth-primed instance
        bp_st = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        bp_st = 1'b0;
        bp_en = 1'b1;
        for (int t = 0; t < 20 && bp_pushes < 8; t++) step(1'b0, 1'b0, 1'b0, 4'd0);
        check("bp_pushes_8", 32'(bp_pushes), 32'd8);
        check("bp_ready_full", 32'(bp_ready), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("bp_ready_hold", 32'(bp_ready), 32'd0);
        for (int t = 0; t < 40 && bp_pos < 16; t++) step(1'b0, 1'b0, 1'b0, 4'd0);
        bp_en = 1'b0;
        check("bp_outputs", 32'(bp_pos), 32'd16);
        check("bp_total_pushes", 32'(bp_pushes), 32'd12);
        check("bp_no_leftover", 32'(bp_q.size()), 32'd0);

        // mid-frame reset at h=5, v=1
        step(1'b0, 1'b1, 1'b0, 4'd0);
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            step(1'b0, 1'b0, (t < 12), 4'(t + 1));
            if (o_hcnt === 11'd5 && o_vcnt === 10'd1) found = 1'b1;
        end
        check("mid_found", 32'(found), 32'd1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_hcnt", 32'(o_hcnt), 32'd0);
        run_nominal("after_rst");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
